qu_busy_table: RTL and testbench



---
 rtl/qu_busy_table.sv | 74 +++++++
 tb/tb_qu_busy_table.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/qu_busy_table.sv
// qu_busy_table
//   Per-physical-register busy-bit table. A set bit means the physical
//   register is still waiting for its result. Bits are set at rename and
//   cleared at writeback through two write ports. Two read ports look up
//   operand readiness.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset (clears every bit)
//   rd1_addr / rd1_out  read port 1: index in, busy bit out (combinational)
//   rd2_addr / rd2_out  read port 2: index in, busy bit out (combinational)
//   wr1_en/addr/in      write port 1: value stored at the next rising edge
//   wr2_en/addr/in      write port 2: same, wins over wr1 on an equal index
//
// Handshake: none. The enables qualify a single cycle, and every port is
// always ready. No valid/ready pair exists on this block.
//
// Configuration
//   QU_BUSY_TABLE_BYPASS_EN  when defined, each read port forwards same-cycle
//                            writes (wr2 first, then wr1) ahead of the stored
//                            bit. rst does not gate this forwarding path.
//                            When undefined, reads see stored state only.

module qu_busy_table #(
  parameter int PHY_RF_DEPTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(PHY_RF_DEPTH)-1:0] rd1_addr,
  output logic                            rd1_out,
  input  logic [$clog2(PHY_RF_DEPTH)-1:0] rd2_addr,
  output logic                            rd2_out,
  input  logic                            wr1_en,
  input  logic [$clog2(PHY_RF_DEPTH)-1:0] wr1_addr,
  input  logic                            wr1_in,
  input  logic                            wr2_en,
  input  logic [$clog2(PHY_RF_DEPTH)-1:0] wr2_addr,
  input  logic                            wr2_in
);

  logic [PHY_RF_DEPTH-1:0] busy_q;
  logic [PHY_RF_DEPTH-1:0] busy_d;

  // wr2 is applied after wr1, so on an equal index wr2_in is the value kept.
  always_comb begin
    busy_d = busy_q;
    if (wr1_en) busy_d[wr1_addr] = wr1_in;
    if (wr2_en) busy_d[wr2_addr] = wr2_in;
  end

  // Reset beats any write that is asserted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

`ifdef QU_BUSY_TABLE_BYPASS_EN
  always_comb begin
    rd1_out = busy_q[rd1_addr];
    if (wr1_en && (wr1_addr == rd1_addr)) rd1_out = wr1_in;
    if (wr2_en && (wr2_addr == rd1_addr)) rd1_out = wr2_in;
  end

  always_comb begin
    rd2_out = busy_q[rd2_addr];
    if (wr1_en && (wr1_addr == rd2_addr)) rd2_out = wr1_in;
    if (wr2_en && (wr2_addr == rd2_addr)) rd2_out = wr2_in;
  end
`else
  assign rd1_out = busy_q[rd1_addr];
  assign rd2_out = busy_q[rd2_addr];
`endif

endmodule

// File: tb/tb_qu_busy_table.sv
// tb_qu_busy_table
//   Self-checking bench for qu_busy_table. Directed cases walk the table's
//   behaviours: reset, single writes, dual writes, collisions, hold, and reset
//   priority. A randomized phase follows and is checked against a
//   table-of-registers reference model.

module tb_qu_busy_table;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic [AW-1:0] rd1_addr, rd2_addr;
  logic          rd1_out, rd2_out;
  logic          wr1_en, wr1_in, wr2_en, wr2_in;
  logic [AW-1:0] wr1_addr, wr2_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one busy flag per physical register.
  bit model_busy [DEPTH];

  // Scoreboard of expected {rd1_out, rd2_out} pairs.
  logic [1:0] exp_q[$];

  qu_busy_table #(.PHY_RF_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd1_addr (rd1_addr),
    .rd1_out  (rd1_out),
    .rd2_addr (rd2_addr),
    .rd2_out  (rd2_out),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_in   (wr1_in),
    .wr2_en   (wr2_en),
    .wr2_addr (wr2_addr),
    .wr2_in   (wr2_in)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Expected read value for one port: stored flag, optionally overridden by
  // a same-cycle write when forwarding is built in.
  function automatic logic model_read(input logic [AW-1:0] a);
    logic v;
    v = model_busy[a];
`ifdef QU_BUSY_TABLE_BYPASS_EN
    if (wr1_en && wr1_addr == a) v = wr1_in;
    if (wr2_en && wr2_addr == a) v = wr2_in;
`endif
    return v;
  endfunction

  // Compare both read ports with the model through the scoreboard.
  task automatic check_model(input string tag);
    logic [1:0] e;
    #1;
    exp_q.push_back({model_read(rd1_addr), model_read(rd2_addr)});
    e = exp_q.pop_front();
    check({tag, ".rd1"}, rd1_out, e[1]);
    check({tag, ".rd2"}, rd2_out, e[0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_wr(input logic e1, input int a1, input logic i1,
                          input logic e2, input int a2, input logic i2);
    wr1_en = e1; wr1_addr = AW'(a1); wr1_in = i1;
    wr2_en = e2; wr2_addr = AW'(a2); wr2_in = i2;
  endtask

  task automatic idle();
    drive_wr(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic set_rd(input int a1, input int a2);
    rd1_addr = AW'(a1);
    rd2_addr = AW'(a2);
  endtask

  // Advance one clock. The model takes the same rising edge, and inputs are
  // re-driven on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model_busy[i] = 1'b0;
    end else begin
      if (wr1_en) model_busy[wr1_addr] = wr1_in;
      if (wr2_en) model_busy[wr2_addr] = wr2_in;
    end
    @(negedge clk);
  endtask

  task automatic read_const(input string tag, input int a1, input int a2,
                            input logic e1, input logic e2);
    set_rd(a1, a2);
    #1;
    check({tag, ".rd1"}, rd1_out, e1);
    check({tag, ".rd2"}, rd2_out, e2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    drive_wr(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    set_rd(0, 0);
    for (int i = 0; i < DEPTH; i++) model_busy[i] = 1'b1;
    @(negedge clk);
    step();
    step();
    idle();

    // One-cycle reset pulse, then sweep every entry on both ports.
    rst = 1'b1; step(); idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, DEPTH - 1 - a);
      #1;
      check("reset_sweep.rd1", rd1_out, 1'b0);
      check("reset_sweep.rd2", rd2_out, 1'b0);
    end

    // Single writes.
    drive_wr(1'b1, 1, 1'b1, 1'b0, 0, 1'b0); step();
    drive_wr(1'b0, 0, 1'b0, 1'b1, 2, 1'b1); step(); idle();
    read_const("single_a2", 2, 2, 1'b1, 1'b1);
    read_const("single_a1", 1, 0, 1'b1, 1'b0);

    // Dual write, different addresses.
    drive_wr(1'b1, 3, 1'b1, 1'b1, 4, 1'b1); step(); idle();
    read_const("dual_34", 3, 4, 1'b1, 1'b1);
    read_const("dual_3_11", 3, 11, 1'b1, 1'b0);
    read_const("dual_11_3", 11, 3, 1'b0, 1'b1);

    // Collisions.
    drive_wr(1'b1, 5, 1'b1, 1'b1, 5, 1'b1); step(); idle();
    read_const("coll_5", 5, 5, 1'b1, 1'b1);
    drive_wr(1'b1, 6, 1'b0, 1'b1, 6, 1'b1); step(); idle();
    read_const("coll_6_w2set", 6, 6, 1'b1, 1'b1);
    drive_wr(1'b1, 6, 1'b1, 1'b1, 6, 1'b0); step(); idle();
    read_const("coll_6_w2clr", 6, 6, 1'b0, 1'b0);

    // Clear and hold.
    drive_wr(1'b1, 3, 1'b0, 1'b0, 0, 1'b0); step(); idle();
    read_const("clear_3", 3, 4, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step();
    read_const("hold_34", 3, 4, 1'b0, 1'b1);
    read_const("hold_12", 1, 2, 1'b1, 1'b1);
    read_const("hold_56", 5, 6, 1'b1, 1'b0);

    // Reset priority. During the reset cycle the reads still show the old state.
    rst = 1'b1;
    drive_wr(1'b1, 7, 1'b1, 1'b0, 0, 1'b0);
    read_const("rst_cycle", 1, 5, 1'b1, 1'b1);
    step(); idle();
    read_const("rst_prio_7", 7, 7, 1'b0, 1'b0);
    read_const("rst_prio_12", 1, 2, 1'b0, 1'b0);
    read_const("rst_prio_45", 4, 5, 1'b0, 1'b0);

`ifdef QU_BUSY_TABLE_BYPASS_EN
    // A same-cycle write is forwarded to the read port.
    drive_wr(1'b1, 9, 1'b1, 1'b0, 0, 1'b0);
    read_const("bypass_9", 9, 8, 1'b1, 1'b0);
    step(); idle();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive_wr(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
               1'($urandom_range(0, 1)));
      // Collisions are biased to show up often.
      if ($urandom_range(0, 3) == 0) wr2_addr = wr1_addr;
      set_rd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) rd1_addr = wr2_addr;
      check_model("rand");
      step();
    end
    idle();

    // Final sweep of the whole table against the model.
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, a);
      check_model("final_sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
